// File: rtl/regfile_pkg.sv
// Shared constants and types for the 16-entry register bank and its read muxes.
package regfile_pkg;
  localparam int REG_COUNT  = 16;
  localparam int REG_ADDR_W = 4;
  localparam int FLAG_W     = 5;

  // Bit positions inside the {C, L, F, Z, N} flag word.
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [FLAG_W-1:0]     flags_t;
endpackage

// File: rtl/reg_bank_if.sv
// Bundle of register-bank write, read, and flag signals shared by the bank and its user.
interface reg_bank_if #(
  parameter int WIDTH = 16
);
  import regfile_pkg::*;

  logic             wr_en;
  reg_addr_t        wr_addr;
  logic [WIDTH-1:0] wr_data;
  reg_addr_t        rd_addr_a;
  reg_addr_t        rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             flags_en;
  flags_t           flags_in;
  flags_t           flags_out;
  logic [15:0]      wr_count;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, flags_en, flags_in,
    input  rd_data_a, rd_data_b, flags_out, wr_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, flags_en, flags_in,
    output rd_data_a, rd_data_b, flags_out, wr_count
  );
endinterface

// File: rtl/mux16to1.sv
// Sixteen-way word selector built as two levels of 4:1 muxes.
module mux16to1
  import regfile_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [REG_COUNT*WIDTH-1:0] din,
  input  logic [REG_ADDR_W-1:0]      sel,
  output logic [WIDTH-1:0]           dout
);

  logic [WIDTH-1:0] word [REG_COUNT];

  for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_word
    assign word[gi] = din[gi*WIDTH +: WIDTH];
  end

  // First level picks within each group of four using the low address bits.
  for (genvar gi = 0; gi < 4; gi++) begin : g_quad
    logic [WIDTH-1:0] q;
    always_comb begin
      unique case (sel[1:0])
        2'd0: q = word[4*gi + 0];
        2'd1: q = word[4*gi + 1];
        2'd2: q = word[4*gi + 2];
        2'd3: q = word[4*gi + 3];
      endcase
    end
  end

  always_comb begin
    unique case (sel[3:2])
      2'd0: dout = g_quad[0].q;
      2'd1: dout = g_quad[1].q;
      2'd2: dout = g_quad[2].q;
      2'd3: dout = g_quad[3].q;
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// Sixteen general registers with two combinational read ports, optional write
// forwarding, a flags register and a running write counter.
module reg_bank
  import regfile_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit BYPASS = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]      rd_data_a,
  output logic [WIDTH-1:0]      rd_data_b,
  input  logic                  flags_en,
  input  logic [FLAG_W-1:0]     flags_in,
  output logic [FLAG_W-1:0]     flags_out,
  output logic [15:0]           wr_count
);

  logic [WIDTH-1:0]           regs_q [REG_COUNT];
  logic [WIDTH-1:0]           regs_d [REG_COUNT];
  logic [REG_COUNT-1:0]       wr_sel;
  logic [REG_COUNT*WIDTH-1:0] regs_flat;
  flags_t                     flags_q;
  flags_t                     flags_d;
  logic [15:0]                wr_count_q;
  logic [15:0]                wr_count_d;
  logic [WIDTH-1:0]           mux_a;
  logic [WIDTH-1:0]           mux_b;

  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      wr_sel[i] = wr_en && (wr_addr == REG_ADDR_W'(i));
      regs_d[i] = wr_sel[i] ? wr_data : regs_q[i];
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (flags_en) begin
      flags_d[FLAG_C] = flags_in[FLAG_C];
      flags_d[FLAG_L] = flags_in[FLAG_L];
      flags_d[FLAG_F] = flags_in[FLAG_F];
      flags_d[FLAG_Z] = flags_in[FLAG_Z];
      flags_d[FLAG_N] = flags_in[FLAG_N];
    end
  end

  // Free-running modulo-2^16 count of accepted writes.
  always_comb begin
    wr_count_d = wr_en ? wr_count_q + 16'd1 : wr_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      flags_q    <= '0;
      wr_count_q <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
      flags_q    <= flags_d;
      wr_count_q <= wr_count_d;
    end
  end

  for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_flat
    assign regs_flat[gi*WIDTH +: WIDTH] = regs_q[gi];
  end

  mux16to1 #(.WIDTH(WIDTH)) u_mux_a (
    .din  (regs_flat),
    .sel  (rd_addr_a),
    .dout (mux_a)
  );

  mux16to1 #(.WIDTH(WIDTH)) u_mux_b (
    .din  (regs_flat),
    .sel  (rd_addr_b),
    .dout (mux_b)
  );

  // A write presented during reset is discarded, so it is not forwarded either.
  if (BYPASS) begin : g_bypass
    logic hit_a;
    logic hit_b;
    assign hit_a     = wr_en && !reset && (wr_addr == rd_addr_a);
    assign hit_b     = wr_en && !reset && (wr_addr == rd_addr_b);
    assign rd_data_a = hit_a ? wr_data : mux_a;
    assign rd_data_b = hit_b ? wr_data : mux_b;
  end else begin : g_no_bypass
    assign rd_data_a = mux_a;
    assign rd_data_b = mux_b;
  end

  assign flags_out = flags_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench driving a non-forwarding and a forwarding reg_bank from one stimulus stream.
module tb_reg_bank;

  localparam int S_A      = 0;
  localparam int S_B      = 1;
  localparam int S_FLAGS  = 2;
  localparam int S_CNT    = 3;
  localparam int S_BA     = 4;
  localparam int S_BB     = 5;
  localparam int S_BFLAGS = 6;
  localparam int S_BCNT   = 7;

  logic clk = 1'b0;
  logic reset;

  reg_bank_if #(.WIDTH(16)) bus ();

  logic [15:0] byp_rd_a;
  logic [15:0] byp_rd_b;
  logic [4:0]  byp_flags;
  logic [15:0] byp_count;

  int checks = 0;
  int errors = 0;

  string       tag_q [$];
  int          sel_q [$];
  logic [15:0] val_q [$];

  always #5 clk = ~clk;

  reg_bank #(.WIDTH(16), .BYPASS(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .rd_addr_a (bus.rd_addr_a),
    .rd_addr_b (bus.rd_addr_b),
    .rd_data_a (bus.rd_data_a),
    .rd_data_b (bus.rd_data_b),
    .flags_en  (bus.flags_en),
    .flags_in  (bus.flags_in),
    .flags_out (bus.flags_out),
    .wr_count  (bus.wr_count)
  );

  reg_bank #(.WIDTH(16), .BYPASS(1'b1)) dut_byp (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .rd_addr_a (bus.rd_addr_a),
    .rd_addr_b (bus.rd_addr_b),
    .rd_data_a (byp_rd_a),
    .rd_data_b (byp_rd_b),
    .flags_en  (bus.flags_en),
    .flags_in  (bus.flags_in),
    .flags_out (byp_flags),
    .wr_count  (byp_count)
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("check %s ok %h", tag, obs);
    end
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_A:      return bus.rd_data_a;
      S_B:      return bus.rd_data_b;
      S_FLAGS:  return {11'd0, bus.flags_out};
      S_CNT:    return bus.wr_count;
      S_BA:     return byp_rd_a;
      S_BB:     return byp_rd_b;
      S_BFLAGS: return {11'd0, byp_flags};
      S_BCNT:   return byp_count;
      default:  return 16'hxxxx;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input logic [15:0] val);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    val_q.push_back(val);
  endtask

  task automatic drain();
    while (sel_q.size() > 0) begin
      string       t;
      int          s;
      logic [15:0] v;
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      v = val_q.pop_front();
      check_eq(t, observe(s), v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [15:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    bus.flags_en  = 1'b0;
    bus.flags_in  = '0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    push_exp("por_cnt", S_CNT, 16'h0000);
    push_exp("por_flags", S_FLAGS, 16'h0000);
    push_exp("por_rd_a", S_A, 16'h0000);
    drain();

    // Fill every register with ones, then reset for one cycle.
    bus.flags_en = 1'b1;
    bus.flags_in = 5'h1F;
    for (int i = 0; i < 16; i++) do_write(4'(i), 16'hFFFF);
    bus.flags_en = 1'b0;
    bus.rd_addr_a = 4'd9;
    #1;
    push_exp("fill_flags", S_FLAGS, 16'h001F);
    push_exp("fill_cnt", S_CNT, 16'd16);
    push_exp("fill_r9", S_A, 16'hFFFF);
    drain();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr_a = 4'(i);
      bus.rd_addr_b = 4'(15 - i);
      #1;
      push_exp($sformatf("rst_a_r%0d", i), S_A, 16'h0000);
      push_exp($sformatf("rst_b_r%0d", 15 - i), S_B, 16'h0000);
      drain();
    end
    push_exp("rst_flags", S_FLAGS, 16'h0000);
    push_exp("rst_cnt", S_CNT, 16'h0000);
    push_exp("rst_bcnt", S_BCNT, 16'h0000);
    drain();

    // Two writes, independent read ports.
    do_write(4'd5, 16'h1234);
    do_write(4'd10, 16'hABCD);
    bus.rd_addr_a = 4'd5;
    bus.rd_addr_b = 4'd10;
    #1;
    push_exp("wr_r5", S_A, 16'h1234);
    push_exp("wr_r10", S_B, 16'hABCD);
    push_exp("wr_byp_r5", S_BA, 16'h1234);
    push_exp("wr_byp_r10", S_BB, 16'hABCD);
    push_exp("wr_cnt", S_CNT, 16'd2);
    drain();
    for (int i = 0; i < 16; i++) begin
      if (i != 5 && i != 10) begin
        bus.rd_addr_a = 4'(i);
        #1;
        push_exp($sformatf("other_r%0d", i), S_A, 16'h0000);
        drain();
      end
    end

    // Same-cycle write and read of R3 on both ports.
    do_write(4'd3, 16'h0001);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 4'd3;
    bus.wr_data   = 16'h00FF;
    bus.rd_addr_a = 4'd3;
    bus.rd_addr_b = 4'd3;
    #1;
    push_exp("fwd_pre_a", S_A, 16'h0001);
    push_exp("fwd_pre_b", S_B, 16'h0001);
    push_exp("fwd_pre_byp_a", S_BA, 16'h00FF);
    push_exp("fwd_pre_byp_b", S_BB, 16'h00FF);
    drain();
    tick();
    bus.wr_en = 1'b0;
    #1;
    push_exp("fwd_post_a", S_A, 16'h00FF);
    push_exp("fwd_post_b", S_B, 16'h00FF);
    push_exp("fwd_post_byp_a", S_BA, 16'h00FF);
    drain();

    // Forwarding on one port only.
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 4'd4;
    bus.wr_data   = 16'h4444;
    bus.rd_addr_a = 4'd3;
    bus.rd_addr_b = 4'd4;
    #1;
    push_exp("fwd1_a", S_A, 16'h00FF);
    push_exp("fwd1_b", S_B, 16'h0000);
    push_exp("fwd1_byp_a", S_BA, 16'h00FF);
    push_exp("fwd1_byp_b", S_BB, 16'h4444);
    drain();
    tick();
    bus.wr_en = 1'b0;
    #1;
    push_exp("fwd1_post_b", S_B, 16'h4444);
    push_exp("fwd1_cnt", S_CNT, 16'd5);
    drain();

    // Reset beats a simultaneous write and flag load.
    reset         = 1'b1;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 4'd7;
    bus.wr_data   = 16'h5555;
    bus.flags_en  = 1'b1;
    bus.flags_in  = 5'b10101;
    bus.rd_addr_a = 4'd7;
    bus.rd_addr_b = 4'd5;
    tick();
    reset        = 1'b0;
    bus.wr_en    = 1'b0;
    bus.flags_en = 1'b0;
    #1;
    push_exp("rprio_r7", S_A, 16'h0000);
    push_exp("rprio_byp_r7", S_BA, 16'h0000);
    push_exp("rprio_flags", S_FLAGS, 16'h0000);
    push_exp("rprio_bflags", S_BFLAGS, 16'h0000);
    push_exp("rprio_cnt", S_CNT, 16'h0000);
    drain();
    do_write(4'd7, 16'h1357);
    push_exp("post_rst_r7", S_A, 16'h1357);
    push_exp("post_rst_cnt", S_CNT, 16'd1);
    drain();

    // Flags alone, then hold.
    bus.flags_en = 1'b1;
    bus.flags_in = 5'b01010;
    tick();
    bus.flags_en = 1'b0;
    bus.flags_in = 5'b11111;
    #1;
    push_exp("flg_load", S_FLAGS, 16'h000A);
    push_exp("flg_r7", S_A, 16'h1357);
    push_exp("flg_r5", S_B, 16'h0000);
    push_exp("flg_cnt", S_CNT, 16'd1);
    drain();
    tick();
    push_exp("flg_hold", S_FLAGS, 16'h000A);
    drain();

    // Flags and write on the same edge.
    bus.flags_en = 1'b1;
    bus.flags_in = 5'b10001;
    do_write(4'd5, 16'h00AA);
    bus.flags_en = 1'b0;
    #1;
    push_exp("both_flags", S_FLAGS, 16'h0011);
    push_exp("both_r5", S_B, 16'h00AA);
    push_exp("both_cnt", S_CNT, 16'd2);
    drain();

    // Counter wrap.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.wr_en = 1'b1;
    for (int n = 0; n < 65535; n++) begin
      bus.wr_addr = 4'(n);
      bus.wr_data = 16'(n);
      tick();
    end
    push_exp("wrap_ffff", S_CNT, 16'hFFFF);
    push_exp("wrap_bffff", S_BCNT, 16'hFFFF);
    drain();
    bus.wr_addr = 4'd15;
    bus.wr_data = 16'hBEEF;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_addr_a = 4'd15;
    #1;
    push_exp("wrap_zero", S_CNT, 16'h0000);
    push_exp("wrap_bzero", S_BCNT, 16'h0000);
    push_exp("wrap_r15", S_A, 16'hBEEF);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width of every register and data port.
REQ-002 SHALL have parameter BYPASS, default 0: 1 = same-cycle write-to-read forwarding on both read ports; 0 = no forwarding.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1: register write enable.
REQ-006 SHALL have port wr_addr  input  4: destination register index R0..R15.
REQ-007 SHALL have port wr_data  input  WIDTH: write data.
REQ-008 SHALL have port rd_addr_a  input  4: read port A register index.
REQ-009 SHALL have port rd_addr_b  input  4: read port B register index.
REQ-010 SHALL have port rd_data_a  output  WIDTH: read port A data, the ALU A operand.
REQ-011 SHALL have port rd_data_b  output  WIDTH: read port B data, the ALU B operand.
REQ-012 SHALL have port flags_en  input  1: flags register write enable.
REQ-013 SHALL have port flags_in  input  5: {C, L, F, Z, N} from ALU.
REQ-014 SHALL have port flags_out  output  5: registered {C, L, F, Z, N}.
REQ-015 SHALL have port wr_count  output  16: count of register writes since reset.

Function
REQ-016 SHALL hold 16 registers R0..R15 of WIDTH bits; R0 is a general register, not hard-wired to zero.
REQ-017 SHALL, on the rising clk edge with wr_en=1 and reset=0, load wr_data into R[wr_addr]; all other registers hold.
REQ-018 SHALL, with wr_en=0, hold all registers unchanged.
REQ-019 SHALL drive rd_data_a = R[rd_addr_a] and rd_data_b = R[rd_addr_b] combinationally, with zero cycles of latency from a change of address.
REQ-020 SHALL, when BYPASS=0 and wr_en=1 with wr_addr equal to a read address, return the old register value on that read port until the edge; the new value appears after the edge.
REQ-021 SHALL, when BYPASS=1 and wr_en=1 with wr_addr equal to a read address, return wr_data on that port in the same cycle; forwarding applies to each port independently, including both ports at once.
REQ-022 SHALL load flags_in into flags_out on the rising edge when flags_en=1, and otherwise hold flags_out.
REQ-023 SHALL treat flags_en and wr_en as independent; both updates take effect on the same edge when asserted together.
REQ-024 SHALL increment wr_count by 1 on each edge with wr_en=1, wrapping from 0xFFFF to 0x0000.
REQ-025 SHALL, with both read addresses equal, return identical data on both ports.

Reset
REQ-026 SHALL, on a rising edge with reset=1, clear R0..R15, flags_out and wr_count to 0; reset overrides wr_en and flags_en on that edge.
REQ-027 SHALL keep the read ports combinational during reset, so they show 0 from the cycle after the reset edge.
REQ-028 SHALL, when reset is asserted mid-sequence, discard any write presented on the same edge; the next write after reset deasserts takes normal effect.

Structure
REQ-029 SHALL place REG_COUNT=16, REG_ADDR_W=4 and the flag bit indices (C=4, L=3, F=2, Z=1, N=0) in the shared package regfile_pkg.
REQ-030 SHALL implement each read port with one instance of the existing mux16to1 sub-module, giving two instances; the write decoder and bypass logic remain in reg_bank.

Verification
REQ-031 SHALL verify reset: write 0xFFFF to every register, then assert reset for 1 cycle -> all 16 reads = 0x0000, flags_out=0, wr_count=0.
REQ-032 SHALL verify write/read: write R5=0x1234 and R10=0xABCD, then set rd_addr_a=5, rd_addr_b=10 -> rd_data_a=0x1234, rd_data_b=0xABCD; all other registers remain 0.
REQ-033 SHALL verify forwarding: with R3=0x0001, assert wr_en, wr_addr=3, wr_data=0x00FF and rd_addr_a=rd_addr_b=3 -> BYPASS=0 reads 0x0001 before the edge and 0x00FF after; BYPASS=1 reads 0x00FF before the edge.
REQ-034 SHALL verify reset priority: assert reset together with wr_en (R7=0x5555) and flags_en (flags_in=5'b10101) -> after the edge R7=0, flags_out=0, wr_count=0.
REQ-035 SHALL verify counter wrap: perform 65536 writes -> wr_count=0x0000, with the 65535th write giving 0xFFFF.
REQ-036 SHALL verify independent flags: hold flags_en=1 with flags_in=5'b01010 and wr_en=0 -> flags_out=5'b01010, registers unchanged; then flags_en=0 with flags_in=5'b11111 -> flags_out holds 5'b01010.
